// File: rtl/ofdmbbp_tx_dac_framer.sv
// ofdmbbp_tx_dac_framer
// TX sample framer for the AD9361 DAC port. Baseband I/Q from the modem is
// buffered in a small FIFO and played out one sample per dac_valid strobe.
// Each command frames (repeat+1) bursts of (length+1)*SYMBOL_LEN samples,
// each followed by `pause` zero strobes. An empty FIFO during a burst emits
// zero, so DAC timing and burst duration never change.
//
// Optional build macro: OFDMBBP_TX_UNDERFLOW_CNT_EN adds the underflow_cnt
// output, a saturating count of zero-inserted burst strobes.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// both valid and ready are high. The source holds its payload stable while
// valid is high and ready is low. ready never depends combinationally on
// valid (s_ready follows the FIFO level, cmd_ready follows the state).
module ofdmbbp_tx_dac_framer #(
    parameter int FIFO_AW    = 5,
    parameter int SYMBOL_LEN = 80,
    parameter int PREFILL    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_length,
    input  logic [6:0]         cmd_repeat,
    input  logic [7:0]         cmd_pause,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [15:0]        s_data_i,
    input  logic [15:0]        s_data_q,
    input  logic               dac_valid,
    output logic [15:0]        dac_data_i,
    output logic [15:0]        dac_data_q,
    output logic               tx_busy,
    output logic               tx_start,
    output logic               tx_done,
    output logic               underflow,
`ifdef OFDMBBP_TX_UNDERFLOW_CNT_EN
    output logic [15:0]        underflow_cnt,
`endif
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int FILL_THR = (PREFILL > DEPTH) ? DEPTH : PREFILL;
    localparam logic [FIFO_AW:0] DEPTH_LVL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] FILL_LVL  = (FIFO_AW+1)'(FILL_THR);
    localparam logic [16:0]      SYM_LEN17 = 17'(SYMBOL_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t state, state_d;

    // ---------------- FIFO ----------------
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               wr_en, rd_en;
    logic [31:0]        head;

    assign s_ready    = (level < DEPTH_LVL);
    assign wr_en      = s_valid && s_ready;
    assign rd_en      = (state == ST_BURST) && dac_valid && (level != '0);
    assign head       = mem[rd_ptr];
    assign fifo_level = level;

    // Sample storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {s_data_i, s_data_q};
    end

    // FIFO pointers and occupancy; a read and write together keep the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ---------------- command framing ----------------
    logic [16:0] burst_len;
    logic [15:0] burst_m1_calc;
    logic [15:0] burst_m1;
    logic [7:0]  pause_len;
    logic [15:0] samp_cnt, samp_cnt_d;
    logic [7:0]  pause_cnt, pause_cnt_d;
    logic [6:0]  rep_left, rep_left_d;
    logic        accept, start_d, done_d, uf_hit;

    // (length+1)*SYMBOL_LEN can reach 65536; the minus-one form always fits.
    assign burst_len     = (17'(cmd_length) + 17'd1) * SYM_LEN17;
    assign burst_m1_calc = 16'(burst_len - 17'd1);

    assign cmd_ready = (state == ST_IDLE);
    assign tx_busy   = (state != ST_IDLE);

    // Next-state and counter logic; counters only move on dac_valid.
    always_comb begin
        state_d     = state;
        samp_cnt_d  = samp_cnt;
        pause_cnt_d = pause_cnt;
        rep_left_d  = rep_left;
        accept      = 1'b0;
        start_d     = 1'b0;
        done_d      = 1'b0;
        uf_hit      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    rep_left_d = cmd_repeat;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (level >= FILL_LVL) begin
                    samp_cnt_d = burst_m1;
                    start_d    = 1'b1;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (dac_valid) begin
                    uf_hit = (level == '0);
                    if (samp_cnt == '0) begin
                        if (pause_len != '0) begin
                            pause_cnt_d = pause_len - 8'd1;
                            state_d     = ST_PAUSE;
                        end else if (rep_left != '0) begin
                            rep_left_d = rep_left - 7'd1;
                            samp_cnt_d = burst_m1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt - 16'd1;
                    end
                end
            end
            ST_PAUSE: begin
                if (dac_valid) begin
                    if (pause_cnt == '0) begin
                        if (rep_left != '0) begin
                            rep_left_d = rep_left - 7'd1;
                            samp_cnt_d = burst_m1;
                            state_d    = ST_BURST;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        pause_cnt_d = pause_cnt - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and the one-cycle start/done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            samp_cnt  <= '0;
            pause_cnt <= '0;
            rep_left  <= '0;
            tx_start  <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_d;
            samp_cnt  <= samp_cnt_d;
            pause_cnt <= pause_cnt_d;
            rep_left  <= rep_left_d;
            tx_start  <= start_d;
            tx_done   <= done_d;
        end
    end

    // Command fields kept for the whole transmission; multiply done once here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_m1  <= '0;
            pause_len <= '0;
        end else if (accept) begin
            burst_m1  <= burst_m1_calc;
            pause_len <= cmd_pause;
        end
    end

    // Sticky underflow flag, cleared when a new command is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         underflow <= 1'b0;
        else if (accept) underflow <= 1'b0;
        else if (uf_hit) underflow <= 1'b1;
    end

`ifdef OFDMBBP_TX_UNDERFLOW_CNT_EN
    // Saturating count of zero-inserted burst strobes for this command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    underflow_cnt <= '0;
        else if (accept)                            underflow_cnt <= '0;
        else if (uf_hit && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif

    // DAC output register: updates only on a strobe, zero unless a sample is read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_data_i <= '0;
            dac_data_q <= '0;
        end else if (dac_valid) begin
            dac_data_i <= rd_en ? head[31:16] : 16'd0;
            dac_data_q <= rd_en ? head[15:0]  : 16'd0;
        end
    end

endmodule

// File: tb/tb_ofdmbbp_tx_dac_framer.sv
// tb_ofdmbbp_tx_dac_framer
// Directed bench for ofdmbbp_tx_dac_framer. A transmission-level model (a
// sample queue plus a slot schedule built from each command) predicts every
// output each cycle; literal totals per scenario pin the model itself.
// Optional build macro: OFDMBBP_TX_UNDERFLOW_CNT_EN (also checks underflow_cnt).
`timescale 1ns/1ps
module tb_ofdmbbp_tx_dac_framer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_length = '0;
    logic [6:0]  cmd_repeat = '0;
    logic [7:0]  cmd_pause = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data_i = '0;
    logic [15:0] s_data_q = '0;
    logic        dac_valid = 1'b0;
    logic [15:0] dac_data_i, dac_data_q;
    logic        tx_busy, tx_start, tx_done, underflow;
    logic [5:0]  fifo_level;
`ifdef OFDMBBP_TX_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    ofdmbbp_tx_dac_framer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_length (cmd_length),
        .cmd_repeat (cmd_repeat),
        .cmd_pause  (cmd_pause),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data_i   (s_data_i),
        .s_data_q   (s_data_q),
        .dac_valid  (dac_valid),
        .dac_data_i (dac_data_i),
        .dac_data_q (dac_data_q),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .underflow  (underflow),
`ifdef OFDMBBP_TX_UNDERFLOW_CNT_EN
        .underflow_cnt (underflow_cnt),
`endif
        .fifo_level (fifo_level)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- DAC strobe generator ----------------
    int dac_div = 2;
    bit dac_en  = 1'b0;
    int dac_ph  = 0;
    always @(negedge clk) begin
        dac_valid = dac_en && (dac_ph == 0);
        dac_ph    = (dac_ph + 1 >= dac_div) ? 0 : dac_ph + 1;
    end

    // ---------------- transmission model ----------------
    // m_phase: 0 = waiting for command, 1 = waiting for prefill, 2 = playing
    logic [31:0] mq[$];
    bit          sched[$];
    int          m_phase = 0;
    int          m_last_sched = 0;
    logic [15:0] e_i = '0, e_q = '0, e_ufcnt = '0;
    bit          e_start = 1'b0, e_done = 1'b0, e_uf = 1'b0, m_strobed = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            sched.delete();
            m_phase   = 0;
            e_i       = '0;
            e_q       = '0;
            e_start   = 1'b0;
            e_done    = 1'b0;
            e_uf      = 1'b0;
            e_ufcnt   = '0;
            m_strobed = 1'b0;
        end else begin
            int          lvl0;
            logic [31:0] out;
            bit          slot;
            lvl0      = mq.size();
            out       = '0;
            e_start   = 1'b0;
            e_done    = 1'b0;
            m_strobed = dac_valid;
            case (m_phase)
                0: if (cmd_valid) begin
                    for (int r = 0; r <= int'(cmd_repeat); r++) begin
                        for (int k = 0; k < (int'(cmd_length) + 1) * 80; k++) sched.push_back(1'b1);
                        for (int k = 0; k < int'(cmd_pause); k++) sched.push_back(1'b0);
                    end
                    m_last_sched = sched.size();
                    m_phase = 1;
                    e_uf    = 1'b0;
                    e_ufcnt = '0;
                end
                1: if (lvl0 >= 16) begin
                    m_phase = 2;
                    e_start = 1'b1;
                end
                2: if (dac_valid) begin
                    slot = sched.pop_front();
                    if (slot) begin
                        if (mq.size() != 0) out = mq.pop_front();
                        else begin
                            e_uf = 1'b1;
                            if (e_ufcnt != 16'hFFFF) e_ufcnt = e_ufcnt + 16'd1;
                        end
                    end
                    if (sched.size() == 0) begin
                        m_phase = 0;
                        e_done  = 1'b1;
                    end
                end
                default: m_phase = 0;
            endcase
            if (dac_valid) begin
                e_i = out[31:16];
                e_q = out[15:0];
            end
            if (s_valid && lvl0 < 32) mq.push_back({s_data_i, s_data_q});
        end
    end

    // ---------------- scoreboard / compare ----------------
    int tot_start = 0, tot_done = 0, tot_strobes = 0;
    int sum_i = 0, sum_q = 0, prev_lvl = 0, lvl_at_start = -1;
    bit counting = 1'b0;

    always @(negedge clk) begin
        check("dac_data_i", dac_data_i, e_i);
        check("dac_data_q", dac_data_q, e_q);
        check("tx_start", tx_start, e_start);
        check("tx_done", tx_done, e_done);
        check("underflow", underflow, e_uf);
        check("tx_busy", tx_busy, m_phase != 0);
        check("cmd_ready", cmd_ready, m_phase == 0);
        check("fifo_level", fifo_level, mq.size());
        check("s_ready", s_ready, mq.size() < 32);
`ifdef OFDMBBP_TX_UNDERFLOW_CNT_EN
        check("underflow_cnt", underflow_cnt, e_ufcnt);
`endif
        if (rst) counting = 1'b0;
        if (counting && m_strobed) begin
            tot_strobes++;
            sum_i += int'(dac_data_i);
            sum_q += int'(dac_data_q);
        end
        if (tx_start) begin
            tot_start++;
            lvl_at_start = prev_lvl;
            counting = 1'b1;
        end
        if (tx_done) begin
            tot_done++;
            counting = 1'b0;
        end
        prev_lvl = int'(fifo_level);
    end

    // ---------------- drivers ----------------
    task automatic push_seq(int first, int n, int gap, bit hold);
        int k = first;
        int budget = 0;
        while (k < first + n && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (s_ready) begin
                s_valid  = 1'b1;
                s_data_i = 16'(k);
                s_data_q = 16'(k + 16384);
                k++;
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                end
            end else begin
                s_valid  = hold;
                s_data_i = 16'hDEAD;
                s_data_q = 16'hBEEF;
            end
        end
        if (k < first + n) check("push_timeout", k, first + n);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_cmd(int len, int rep, int pz);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_timeout", cmd_ready, 1);
        cmd_length = 8'(len);
        cmd_repeat = 7'(rep);
        cmd_pause  = 8'(pz);
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(int target, int budget);
        int n = 0;
        while (tot_done < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (tot_done < target) check("done_timeout", tot_done, target);
    endtask

    int b_start, b_done, b_str, b_sum_i, b_sum_q;
    task automatic snap();
        b_start = tot_start;
        b_done  = tot_done;
        b_str   = tot_strobes;
        b_sum_i = sum_i;
        b_sum_q = sum_q;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_dac_i", dac_data_i, 0);
        check("rst_dac_q", dac_data_q, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_underflow", underflow, 0);
        check("rst_level", fifo_level, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_done", tx_done, 0);

        // single 80-sample burst, ramp in order
        dac_div = 2;
        dac_en  = 1'b1;
        snap();
        fork
            push_seq(0, 80, 0, 1'b0);
            begin
                send_cmd(0, 0, 0);
                wait_done(b_done + 1, 3000);
            end
        join
        #1;
        check("t1_starts", tot_start - b_start, 1);
        check("t1_dones", tot_done - b_done, 1);
        check("t1_strobes", tot_strobes - b_str, 80);
        check("t1_sum_i", sum_i - b_sum_i, 3160);
        check("t1_sum_q", sum_q - b_sum_q, 1313880);
        check("t1_underflow", underflow, 0);

        // two bursts with a 4-strobe pause after each
        snap();
        fork
            push_seq(0, 160, 0, 1'b0);
            begin
                send_cmd(0, 1, 4);
                wait_done(b_done + 1, 5000);
            end
        join
        #1;
        check("t2_sched_len", m_last_sched, 168);
        check("t2_starts", tot_start - b_start, 1);
        check("t2_dones", tot_done - b_done, 1);
        check("t2_strobes", tot_strobes - b_str, 168);
        check("t2_sum_i", sum_i - b_sum_i, 12720);
        check("t2_underflow", underflow, 0);

        // only 40 samples for an 80-sample burst, strobe every clk
        dac_div = 1;
        snap();
        fork
            push_seq(0, 40, 0, 1'b0);
            begin
                send_cmd(0, 0, 0);
                wait_done(b_done + 1, 3000);
            end
        join
        #1;
        check("t3_strobes", tot_strobes - b_str, 80);
        check("t3_sum_i", sum_i - b_sum_i, 780);
        check("t3_underflow", underflow, 1);
`ifdef OFDMBBP_TX_UNDERFLOW_CNT_EN
        check("t3_underflow_cnt", underflow_cnt, 40);
`endif

        // fill to full with no strobes, then drain
        dac_en = 1'b0;
        push_seq(0, 32, 0, 1'b1);
        s_valid  = 1'b1;
        s_data_i = 16'hDEAD;
        s_data_q = 16'hBEEF;
        repeat (8) @(negedge clk);
        #1;
        check("t4_level_full", fifo_level, 32);
        check("t4_s_ready_low", s_ready, 0);
        s_valid = 1'b0;
        dac_div = 2;
        dac_en  = 1'b1;
        snap();
        send_cmd(0, 0, 0);
        wait_done(b_done + 1, 3000);
        #1;
        check("t4_strobes", tot_strobes - b_str, 80);
        check("t4_sum_i", sum_i - b_sum_i, 496);
        check("t4_underflow", underflow, 1);
`ifdef OFDMBBP_TX_UNDERFLOW_CNT_EN
        check("t4_underflow_cnt", underflow_cnt, 48);
`endif

        // command accepted with 10 samples buffered; start right after level 16
        dac_div = 4;
        push_seq(0, 10, 0, 1'b0);
        #1;
        check("t5_level_10", fifo_level, 10);
        snap();
        fork
            begin
                push_seq(10, 6, 2, 1'b0);
                push_seq(16, 64, 0, 1'b0);
            end
            begin
                send_cmd(0, 0, 0);
                wait_done(b_done + 1, 5000);
            end
        join
        #1;
        check("t5_lvl_at_start", lvl_at_start, 16);
        check("t5_starts", tot_start - b_start, 1);
        check("t5_strobes", tot_strobes - b_str, 80);
        check("t5_sum_i", sum_i - b_sum_i, 3160);

        // reset in the middle of a burst: abort, no done pulse
        dac_div = 2;
        push_seq(0, 30, 0, 1'b0);
        snap();
        send_cmd(0, 0, 0);
        repeat (40) @(negedge clk);
        #1;
        check("t6_busy_mid", tx_busy, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("t6_no_done", tot_done - b_done, 0);
        check("t6_busy", tx_busy, 0);
        check("t6_level", fifo_level, 0);
        check("t6_dac_i", dac_data_i, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        check("t6_s_ready", s_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
